// File: rtl/mem_ctrl32_pkg.sv
// Shared types for the load/store front end: size codes, FSM states, captured request.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_pkg;

    localparam int DEPTH_DEF = 1024;

    // Request size encoding as driven by the CPU memory stage
    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_X = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RSP  = 2'd3
    } state_e;

    // Request fields held for the duration of one transaction
    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] adr;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/mem_ctrl32_if.sv
// CPU-side request/response bundle of the load/store front end.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both the request and the response channel.
interface mem_ctrl32_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sext;
    logic [31:0] req_adr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    // CPU memory stage side
    modport master (
        output req_valid, req_we, req_size, req_sext, req_adr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    // Controller side
    modport slave (
        input  req_valid, req_we, req_size, req_sext, req_adr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mem_ctrl32_lane_align.sv
// Byte/half lane extraction with optional sign extension, store-lane merge, misalign detect.
// Latency: purely combinational.
// Backpressure: none.
module lane_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        sext,
    output logic [31:0] ld_val,
    output logic [31:0] st_word,
    output logic        misalign
);

    logic [7:0]  b;
    logic [15:0] h;

    // Select the addressed lane for loads and splice new data into it for stores
    always_comb begin
        misalign = 1'b0;
        ld_val   = '0;
        st_word  = word;
        b        = word[{offset, 3'b000} +: 8];
        h        = word[{offset[1], 4'b0000} +: 16];
        case (size)
            SZ_B: begin
                ld_val                         = {{24{sext & b[7]}}, b};
                st_word[{offset, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_H: begin
                misalign                             = offset[0];
                ld_val                               = {{16{sext & h[15]}}, h};
                st_word[{offset[1], 4'b0000} +: 16]  = wdata[15:0];
            end
            SZ_W: begin
                misalign = |offset;
                ld_val   = word;
                st_word  = wdata;
            end
            default: begin
                misalign = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_ctrl32.sv
// Byte/half/word load-store front end for a word-wide RAM; sub-word stores use read-modify-write.
// Latency: req accept to rsp_valid: error 1, load 2, word store 2, sub-word store 3 cycles.
// Backpressure: one transaction in flight; req_ready only in IDLE, response held until rsp_ready.
module mem_ctrl32
    import mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    mem_ctrl32_if.slave       bus,
    output logic              ram_en,
    output logic              ram_we,
    output logic [31:0]       ram_adr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout
);

    state_e      state_q, state_d;
    req_t        req_q;
    logic [31:0] word_q;
    logic        err_q;

    logic        accept;
    logic        range_err;
    logic        req_err;
    logic [1:0]  la_size;
    logic [1:0]  la_off;
    logic [31:0] ld_val;
    logic [31:0] st_word;
    logic        misalign;
    logic        live;
    logic        ram_act;

    assign live    = !rst;
    assign accept  = bus.req_valid && bus.req_ready;
    assign ram_act = live && (state_q == S_RD || state_q == S_WR);

    // In IDLE the aligner judges the incoming request; afterwards it serves the captured one
    assign la_size = (state_q == S_IDLE) ? bus.req_size       : req_q.size;
    assign la_off  = (state_q == S_IDLE) ? bus.req_adr[1:0]   : req_q.adr[1:0];

    assign range_err = ({2'b00, bus.req_adr[31:2]} >= 32'(DEPTH));
    assign req_err   = misalign || (bus.req_size == SZ_X) || range_err;

    lane_align u_lane (
        .word     (word_q),
        .wdata    (req_q.wdata),
        .size     (la_size),
        .offset   (la_off),
        .sext     (req_q.sext),
        .ld_val   (ld_val),
        .st_word  (st_word),
        .misalign (misalign)
    );

    // State register; reset aborts any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state: errors skip the RAM, word stores skip the read
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_err)                                  state_d = S_RSP;
                    else if (!bus.req_we || bus.req_size != SZ_W) state_d = S_RD;
                    else                                          state_d = S_WR;
                end
            end
            S_RD:    state_d = req_q.we ? S_WR : S_RSP;
            S_WR:    state_d = S_RSP;
            S_RSP:   if (bus.rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Capture the request on accept and the RAM word during the read cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q  <= '0;
            word_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                req_q.we    <= bus.req_we;
                req_q.size  <= bus.req_size;
                req_q.sext  <= bus.req_sext;
                req_q.adr   <= bus.req_adr;
                req_q.wdata <= bus.req_wdata;
                err_q       <= req_err;
            end
            if (state_q == S_RD) word_q <= ram_dout;
        end
    end

    // Outputs are forced to idle values while reset is asserted, which also blocks a pending write
    assign ram_en  = ram_act;
    assign ram_we  = live && (state_q == S_WR);
    assign ram_adr = ram_act ? {2'b00, req_q.adr[31:2]} : '0;
    assign ram_din = (live && state_q == S_WR) ?
                     ((req_q.size == SZ_W) ? req_q.wdata : st_word) : '0;

    assign bus.req_ready = live && (state_q == S_IDLE);
    assign bus.rsp_valid = live && (state_q == S_RSP);
    assign bus.rsp_err   = live && (state_q == S_RSP) && err_q;
    assign bus.rsp_rdata = (live && state_q == S_RSP && !err_q && !req_q.we) ? ld_val : '0;

endmodule

// File: tb/tb_mem_ctrl32.sv
module tb_mem_ctrl32;

    logic        clk;
    logic        rst;
    logic        ram_en, ram_we;
    logic [31:0] ram_adr, ram_din, ram_dout;

    mem_ctrl32_if bus ();

    mem_ctrl32 #(.DEPTH(1024)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_adr  (ram_adr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model plus access counters
    logic [31:0] mem [0:1023] = '{default: 32'h0};
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          en_cnt = 0;

    assign ram_dout = mem[ram_adr[9:0]];

    always @(posedge clk) begin
        if (ram_en) en_cnt <= en_cnt + 1;
        if (ram_en && !ram_we) rd_cnt <= rd_cnt + 1;
        if (ram_en && ram_we) begin
            wr_cnt <= wr_cnt + 1;
            mem[ram_adr[9:0]] <= ram_din;
        end
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compare each accepted response against the scoreboard head
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && bus.rsp_valid && bus.rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", sb.size(), 1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_rdata", bus.rsp_rdata, e.rd);
                    chk("rsp_err", {31'b0, bus.rsp_err}, {31'b0, e.err});
                end
            end
        end
    end

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_rdy"}, {31'b0, bus.req_ready}, 32'd1);
    endtask

    // Issue one request, check its response latency, then accept the response (optionally after a hold)
    task automatic do_req(input string nm, input bit we, input logic [1:0] sz, input bit sx,
                          input logic [31:0] adr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input bit exp_err, input int exp_lat,
                          input int hold);
        int   lat;
        exp_t e;
        wait_ready(nm);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_size  = sz;
        bus.req_sext  = sx;
        bus.req_adr   = adr;
        bus.req_wdata = wd;
        e.rd  = exp_rd;
        e.err = exp_err;
        sb.push_back(e);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus.rsp_valid) break;
        end
        chk({nm, "_lat"}, lat, exp_lat);
        if (hold > 0) begin
            // A competing request must be ignored while the response is stalled
            bus.req_valid = 1'b1;
            bus.req_we    = 1'b1;
            bus.req_size  = 2'b10;
            bus.req_adr   = 32'h0;
            bus.req_wdata = 32'hBAD0BAD0;
            for (int i = 0; i < hold; i++) begin
                chk({nm, "_hold_vld"}, {31'b0, bus.rsp_valid}, 32'd1);
                chk({nm, "_hold_rd"}, bus.rsp_rdata, exp_rd);
                chk({nm, "_hold_err"}, {31'b0, bus.rsp_err}, {31'b0, exp_err});
                chk({nm, "_hold_rdy"}, {31'b0, bus.req_ready}, 32'd0);
                @(negedge clk);
            end
            bus.req_valid = 1'b0;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
    endtask

    int en0, rd0, wr0, n;

    initial begin
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_size  = 2'b00;
        bus.req_sext  = 1'b0;
        bus.req_adr   = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;   // ignored while no response is pending
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_ram_en", {31'b0, ram_en}, 32'd0);
        chk("rst_ram_adr", ram_adr, 32'd0);
        chk("rst_ram_din", ram_din, 32'd0);
        rst = 1'b0;
        bus.rsp_ready = 1'b0;
        @(negedge clk);

        // Word store then word load
        do_req("st_w",  1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, 0);
        chk("mem4_w", mem[4], 32'hDEADBEEF);
        do_req("ld_w",  0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2, 0);

        // Sub-word store: one read then one write
        rd0 = rd_cnt; wr0 = wr_cnt;
        do_req("st_b",  1, 2'b00, 0, 32'h13, 32'h12, 32'h0, 0, 3, 0);
        chk("st_b_rds", rd_cnt - rd0, 1);
        chk("st_b_wrs", wr_cnt - wr0, 1);
        chk("mem4_b", mem[4], 32'h12ADBEEF);
        do_req("ld_b13", 0, 2'b00, 1, 32'h13, 32'h0, 32'h00000012, 0, 2, 0);
        do_req("ld_b12", 0, 2'b00, 1, 32'h12, 32'h0, 32'hFFFFFFAD, 0, 2, 0);
        do_req("ld_hz",  0, 2'b01, 0, 32'h10, 32'h0, 32'h0000BEEF, 0, 2, 0);
        do_req("ld_hs",  0, 2'b01, 1, 32'h10, 32'h0, 32'hFFFFBEEF, 0, 2, 0);
        do_req("ld_hhi", 0, 2'b01, 0, 32'h12, 32'h0, 32'h000012AD, 0, 2, 0);

        // Rejected requests never touch the RAM
        en0 = en_cnt;
        do_req("e_hmis", 0, 2'b01, 0, 32'h11, 32'h0, 32'h0, 1, 1, 0);
        do_req("e_wmis", 1, 2'b10, 0, 32'h12, 32'hCAFEF00D, 32'h0, 1, 1, 0);
        do_req("e_size", 0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1, 1, 0);
        do_req("e_rng",  0, 2'b10, 0, 32'h1000, 32'h0, 32'h0, 1, 1, 0);
        chk("err_no_ram", en_cnt - en0, 0);
        chk("mem4_err", mem[4], 32'h12ADBEEF);

        // Response stall for five cycles
        do_req("hold", 0, 2'b10, 0, 32'h10, 32'h0, 32'h12ADBEEF, 0, 2, 5);
        chk("mem0_hold", mem[0], 32'h0);

        // Reset while a byte store sits in its write cycle
        do_req("st_w5", 1, 2'b10, 0, 32'h14, 32'h11223344, 32'h0, 0, 2, 0);
        wait_ready("rst_st");
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = 2'b00;
        bus.req_sext  = 1'b0;
        bus.req_adr   = 32'h14;
        bus.req_wdata = 32'h77;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (ram_we) break;
        end
        chk("rst_wr_seen", {31'b0, ram_we}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_we", {31'b0, ram_we}, 32'd0);
        chk("rst_mid_en", {31'b0, ram_en}, 32'd0);
        chk("rst_mid_din", ram_din, 32'd0);
        chk("rst_mid_rdy", {31'b0, bus.req_ready}, 32'd0);
        chk("rst_mid_vld", {31'b0, bus.rsp_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_rel_rdy", {31'b0, bus.req_ready}, 32'd1);
        chk("mem5_rst", mem[5], 32'h11223344);
        @(negedge clk);
        chk("rst_no_rsp", {31'b0, bus.rsp_valid}, 32'd0);

        // Normal operation resumes
        do_req("ld_b15", 0, 2'b00, 0, 32'h15, 32'h0, 32'h00000033, 0, 2, 0);
        do_req("st_h16", 1, 2'b01, 0, 32'h16, 32'hFFFF8001, 32'h0, 0, 3, 0);
        chk("mem5_h", mem[5], 32'h80013344);

        repeat (3) @(negedge clk);
        chk("sb_leftover", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_ctrl32.md
# mem_ctrl32

Load/store front end sitting directly upstream of the word-wide `ram32` data memory. It accepts one byte/half/word request at a time from the CPU memory stage and turns it into word accesses. Sub-word stores become a read-modify-write sequence and loads are lane-extracted with optional sign extension. Misaligned, illegal-size and out-of-range requests are rejected without touching the RAM.

## Interface
- `DEPTH`, 1024: RAM depth in words; valid word index is 0..DEPTH-1.
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: block can accept (IDLE only).
- `req_we` input 1: 1 = store, 0 = load.
- `req_size` input 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_sext` input 1: sign-extend load result (ignored for word/store).
- `req_adr` input 32: byte address, little-endian.
- `req_wdata` input 32: store data, right-justified.
- `rsp_valid` output 1: response present; held until accepted.
- `rsp_ready` input 1: consumer takes response.
- `rsp_rdata` output 32: load data (0 for stores/errors).
- `rsp_err` output 1: request rejected (misaligned, size 11, word index ≥ DEPTH).
- `ram_en`, `ram_we` output 1: RAM enable / write enable.
- `ram_adr` output 32: word index (byte address >> 2).
- `ram_din` output 32: word to write.
- `ram_dout` input 32: RAM read word, combinational from `ram_adr`.

## Operation
- States: IDLE, RD, WR, RSP.
- IDLE: `req_ready`=1. On `req_valid`, capture adr/size/we/sext/wdata and branch:
  - error → RSP with err=1;
  - load or sub-word store → RD;
  - word store → WR.
- RD: `ram_en`=1, `ram_we`=0, `ram_adr`=captured word index; register `ram_dout` into `word_q`.
  - load → RSP, `rsp_rdata` = lane-extracted/extended `word_q`;
  - sub-word store → WR.
- WR: `ram_en`=1, `ram_we`=1.
  - `ram_din` = wdata for word stores;
  - for sub-word stores, `ram_din` = `word_q` with the addressed byte/half lane replaced by wdata[7:0]/[15:0]. Other lanes are unchanged.
  - → RSP.
- RSP: `rsp_valid`=1. Data and err are stable while `rsp_ready`=0. On `rsp_ready` → IDLE.
- Lane select: byte lane = adr[1:0], half lane = adr[1].
  - Half requires adr[0]=0; word requires adr[1:0]=00. Violations are errors.
- Extension: byte/half zero-extended unless `req_sext`=1, in which case bit 7/15 is replicated.
- `ram_en`/`ram_we` are 0 in IDLE and RSP. Both are gated with `!rst`, so no RAM write occurs in a reset cycle.

## Timing
- Reset values: state IDLE, `req_ready`=0 while `rst`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `ram_en`=0, `ram_we`=0, `ram_adr`=0, `ram_din`=0.
- Request accepted at edge N (IDLE, valid&ready). Earliest `rsp_valid` is then:
  - load: N+2;
  - word store: N+2;
  - sub-word store: N+3;
  - error: N+1.
- Response accepted at edge M → `req_ready`=1 from M; next request can be accepted at M+1. No back-to-back overlap.
- `rsp_valid` is never dropped without `rsp_ready`. `req_ready`=0 in RD/WR/RSP.
- Reset mid-operation: abort to IDLE in the next cycle. A write pending in WR during the `rst` cycle is suppressed. The pending response is discarded.
- `rsp_ready` high while `rsp_valid` low has no effect.

## Structure
- Package `mem_pkg`: size encoding (SZ_B/SZ_H/SZ_W), state enum, DEPTH default.
- Sub-module `lane_align`: purely combinational.
  - Inputs: word, wdata, size, offset, sext.
  - Outputs: extracted load value, merged store word, misalign flag.
  - Used for both the RD result and the WR merge.

## Test plan
- Word store adr 0x10, data 0xDEADBEEF, then word load 0x10 → RAM word 4 = 0xDEADBEEF; load rsp_rdata=0xDEADBEEF, err=0, rsp_valid at N+2.
- After above, byte store 0x13 data 0x12, then byte load 0x13 with sext=1 → word 4 = 0x12ADBEEF, exactly one RD then one WR; sext load of 0x12 returns 0x00000012. Byte load 0x12 sext=1 → 0xFFFFFFAD.
- Half load 0x10 sext=0 → 0x0000BEEF; sext=1 → 0xFFFFBEEF.
- Half load 0x11, word store 0x12, size=11, word load 0x1000 (DEPTH=1024) → each rsp_err=1 at N+1, rdata=0, `ram_en` never asserted, RAM unchanged.
- Hold `rsp_ready`=0 for 5 cycles → rsp_valid/rdata/err stable, `req_ready`=0, new req_valid ignored.
- Assert `rst` for one cycle while in WR of a byte store → `ram_we` stays 0, RAM word unchanged, outputs at reset values, `req_ready`=1 the cycle after release.
